ifetch_unit: RTL



---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// IR field positions and parameter defaults.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ifetch_state_e;

    localparam int OPCODE_MSB      = 15;
    localparam int OPCODE_LSB      = 11;
    localparam int LABEL11_MSB     = 10;
    localparam int LABEL11_LSB     = 0;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: reads imem at the latched PC, captures the word into IR,
// pulses pc_ce per completed fetch. Optional REQ timeout via IFETCH_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for fetch_start; pc_in latched on exit
// REQ     | mem_rd held high until mem_ready (or timeout when enabled)
// DONE    | one cycle: ir_valid/pc_ce pulse, fetch_cnt already advanced
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [4:0]        opcode,
    output logic [10:0]       label11,
    output logic              ir_valid,
    output logic              pc_ce,
    output logic              busy,
    output logic [15:0]       fetch_cnt,
    output logic              fetch_err
);

    ifetch_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [15:0]       fetch_cnt_q, fetch_cnt_d;
    logic              mem_rd_q, mem_rd_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pc_ce_q, pc_ce_d;
    logic              busy_q, busy_d;
    logic              fetch_err_q, fetch_err_d;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef IFETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        fetch_cnt_d = fetch_cnt_q;
        mem_rd_d    = 1'b0;
        ir_valid_d  = 1'b0;
        pc_ce_d     = 1'b0;
        busy_d      = 1'b0;
        fetch_err_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    mem_addr_d = pc_in;
                    state_d    = ST_REQ;
                    mem_rd_d   = 1'b1;
                    busy_d     = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    ir_d        = mem_rdata;
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                    state_d     = ST_DONE;
                    ir_valid_d  = 1'b1;
                    pc_ce_d     = 1'b1;
                    busy_d      = 1'b1;
                end else begin
`ifdef IFETCH_TIMEOUT_EN
                    // Abort after TIMEOUT_CYC unanswered REQ cycles; no PC advance.
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_d     = ST_IDLE;
                        fetch_err_d = 1'b1;
                    end else begin
                        tmo_d    = tmo_q + 1'b1;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                    end
`else
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            fetch_cnt_q <= '0;
            mem_rd_q    <= 1'b0;
            ir_valid_q  <= 1'b0;
            pc_ce_q     <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            fetch_cnt_q <= fetch_cnt_d;
            mem_rd_q    <= mem_rd_d;
            ir_valid_q  <= ir_valid_d;
            pc_ce_q     <= pc_ce_d;
            busy_q      <= busy_d;
            fetch_err_q <= fetch_err_d;
`ifdef IFETCH_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign label11   = ir_q[LABEL11_MSB:LABEL11_LSB];
    assign ir_valid  = ir_valid_q;
    assign pc_ce     = pc_ce_q;
    assign busy      = busy_q;
    assign fetch_cnt = fetch_cnt_q;
    assign fetch_err = fetch_err_q;

endmodule
